// File: rtl/prbs6_checker_if.sv
// Bundle of the serial PRBS input, its qualifiers and the checker status
// outputs. The master side feeds bits in; the slave side is the checker.
interface prbs6_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             in;       // serial PRBS bit from the generator
  logic             en;       // bit-valid qualifier
  logic             clr;      // synchronous clear of err_cnt
  logic             locked;   // checker is in LOCKED state
  logic             err;      // one-cycle pulse per mismatching bit
  logic [CNT_W-1:0] err_cnt;  // saturating mismatch count

  modport master (
    output in, en, clr,
    input  locked, err, err_cnt
  );

  modport slave (
    input  in, en, clr,
    output locked, err, err_cnt
  );
endinterface

// File: rtl/prbs6_checker.sv
// Self-synchronising checker for the x^6+x^5+1 PRBS stream. It seeds its
// history from the line, searches for LOCK_CNT consecutive correct
// predictions, then freewheels and flags every mismatching bit. Too many
// errors within one 63-bit frame drops it back to searching.
module prbs6_checker #(
  parameter int LOCK_CNT  = 16,  // consecutive matches to declare lock (1..63)
  parameter int ERR_LIMIT = 4,   // errors per 63-bit frame that drop lock (1..63)
  parameter int CNT_W     = 16   // width of the error counter
) (
  input  logic           clk,
  input  logic           rst_n,
  prbs6_checker_if.slave bus
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [5:0] LOCK_TARGET = 6'(LOCK_CNT);
  localparam logic [5:0] ERR_TARGET  = 6'(ERR_LIMIT);
  localparam logic [5:0] FRAME_LAST  = 6'd62;

  state_e           r_state;
  logic [5:0]       r_hist;       // [0] newest bit, [5] oldest
  logic [2:0]       r_fill_cnt;
  logic [5:0]       r_match_cnt;
  logic [5:0]       r_frame_cnt;
  logic [5:0]       r_frame_err;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_pred;
  logic             w_hist_zero;
  logic             w_miss;
  logic [5:0]       w_match_inc;
  logic [5:0]       w_ferr_inc;
  logic             w_cnt_max;
  logic             w_count_err;

  // The recurrence o[n+6] = o[n+5] ^ o[n] predicts the next bit from the
  // oldest and newest history bits.
  assign w_pred      = r_hist[5] ^ r_hist[0];
  assign w_hist_zero = (r_hist == 6'd0);
  assign w_miss      = (bus.in != w_pred);
  assign w_match_inc = r_match_cnt + 6'd1;
  assign w_ferr_inc  = r_frame_err + 6'd1;
  assign w_cnt_max   = &r_err_cnt;
  assign w_count_err = bus.en && (r_state == LOCKED) && w_miss;

  // History shift: fed from the line until locked, then freewheels on its
  // own prediction so line errors never corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 6'd0;
    end else if (bus.en) begin
      if (r_state == LOCKED) begin
        r_hist <= {r_hist[4:0], w_pred};
      end else begin
        r_hist <= {r_hist[4:0], bus.in};
      end
    end
  end

  // Acquisition / tracking state machine with registered locked and err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_fill_cnt  <= 3'd0;
      r_match_cnt <= 6'd0;
      r_frame_cnt <= 6'd0;
      r_frame_err <= 6'd0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.en) begin
        case (r_state)
          FILL: begin
            r_fill_cnt <= r_fill_cnt + 3'd1;
            if (r_fill_cnt == 3'd5) begin
              r_state     <= SEARCH;
              r_match_cnt <= 6'd0;
            end
          end

          SEARCH: begin
            // An all-zero history predicts zeros forever; never let a
            // stuck-at-0 line count as matches.
            if (!w_miss && !w_hist_zero) begin
              r_match_cnt <= w_match_inc;
              if (w_match_inc == LOCK_TARGET) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_frame_cnt <= 6'd0;
                r_frame_err <= 6'd0;
              end
            end else begin
              r_match_cnt <= 6'd0;
            end
          end

          LOCKED: begin
            r_err <= w_miss;
            // A mismatch on the wrap bit still belongs to the ending frame,
            // so the limit test uses the incremented count before clearing.
            if (w_miss && (w_ferr_inc == ERR_TARGET)) begin
              r_state     <= SEARCH;
              r_locked    <= 1'b0;
              r_match_cnt <= 6'd0;
            end
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= 6'd0;
              r_frame_err <= 6'd0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 6'd1;
              if (w_miss) begin
                r_frame_err <= w_ferr_inc;
              end
            end
          end

          default: begin
            r_state <= FILL;
          end
        endcase
      end
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment and
  // loss of lock leaves the count untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.clr) begin
      r_err_cnt <= '0;
    end else if (w_count_err && !w_cnt_max) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs6_checker.sv
// Bench for prbs6_checker: a reference generator drives two checkers (16-bit
// and 4-bit error counters) and a queue-based model predicts every output.
module tb_prbs6_checker;

  localparam int LOCK_CNT  = 16;
  localparam int ERR_LIMIT = 4;
  localparam int S_FILL    = 0;
  localparam int S_SEARCH  = 1;
  localparam int S_LOCKED  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prbs6_checker_if #(.CNT_W(16)) if16 ();
  prbs6_checker_if #(.CNT_W(4))  if4 ();

  prbs6_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );

  prbs6_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // one full period of the generator output, and its current phase
  bit seq[63];
  int g;

  // reference model: last six received/predicted bits, oldest first
  bit mh[$];
  int m_state, m_fill, m_match, m_frame, m_ferr;
  int m_cnt16, m_cnt4;
  bit m_locked, m_err;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mh.delete();
    for (int i = 0; i < 6; i++) mh.push_back(1'b0);
    m_state = S_FILL; m_fill = 0; m_match = 0; m_frame = 0; m_ferr = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_locked = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void push_hist(input bit b);
    mh.push_back(b);
    void'(mh.pop_front());
  endfunction

  // One clock of the specification's rules, at plain-integer level.
  function automatic void model_step(input bit b, input bit e, input bit c);
    bit pred, all_zero, bad;
    m_err = 1'b0;
    if (e) begin
      pred = mh[0] ^ mh[5];
      all_zero = 1'b1;
      foreach (mh[i]) if (mh[i]) all_zero = 1'b0;
      case (m_state)
        S_FILL: begin
          push_hist(b);
          m_fill++;
          if (m_fill == 6) begin m_state = S_SEARCH; m_match = 0; end
        end
        S_SEARCH: begin
          if (b == pred && !all_zero) m_match++;
          else m_match = 0;
          push_hist(b);
          if (m_match == LOCK_CNT) begin m_state = S_LOCKED; m_frame = 0; m_ferr = 0; end
        end
        default: begin
          bad = (b != pred);
          push_hist(pred);
          if (bad) begin
            m_err = 1'b1;
            if (!c) begin
              if (m_cnt16 < 65535) m_cnt16++;
              if (m_cnt4 < 15) m_cnt4++;
            end
            m_ferr++;
          end
          if (bad && m_ferr == ERR_LIMIT) begin
            m_state = S_SEARCH; m_match = 0;
          end else if (m_frame == 62) begin
            m_frame = 0; m_ferr = 0;
          end else begin
            m_frame++;
          end
        end
      endcase
    end
    if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    m_locked = (m_state == S_LOCKED);
  endfunction

  task automatic drive(input bit b, input bit e, input bit c);
    if16.in = b; if16.en = e; if16.clr = c;
    if4.in  = b; if4.en  = e; if4.clr  = c;
  endtask

  // Called at a falling edge: apply inputs, clock once, compare outputs.
  task automatic step(input bit b, input bit e, input bit c);
    drive(b, e, c);
    @(posedge clk);
    model_step(b, e, c);
    @(negedge clk);
    chk("locked16", if16.locked,  m_locked);
    chk("err16",    if16.err,     m_err);
    chk("cnt16",    if16.err_cnt, m_cnt16);
    chk("locked4",  if4.locked,   m_locked);
    chk("err4",     if4.err,      m_err);
    chk("cnt4",     if4.err_cnt,  m_cnt4);
  endtask

  // Generator-gated bit: the generator advances only on enabled cycles.
  task automatic gstep(input bit e, input bit flip, input bit c);
    step(seq[g] ^ flip, e, c);
    if (e) g = (g + 1) % 63;
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic pulse_reset();
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_locked16", if16.locked, 0);
    chk("rst_err16",    if16.err, 0);
    chk("rst_cnt16",    if16.err_cnt, 0);
    chk("rst_cnt4",     if4.err_cnt, 0);
    model_reset();
    g = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input string tag);
    for (int k = 0; k < 200 && !m_locked; k++) gstep(1'b1, 1'b0, 1'b0);
    chk(tag, if16.locked, 1);
  endtask

  initial begin
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0; seq[4] = 0; seq[5] = 1;
    for (int n = 0; n < 57; n++) seq[n + 6] = seq[n + 5] ^ seq[n];
    g = 0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // clean stream from reset: lock on edge 22, no errors over 1000 bits
    $display("[TB] clean stream acquisition, 1000 bits");
    for (int i = 1; i <= 1000; i++) begin
      gstep(1'b1, 1'b0, 1'b0);
      if (i == 21) chk("pre_lock21", if16.locked, 0);
      if (i == 22) chk("lock_at22", if16.locked, 1);
    end
    chk("clean_cnt", if16.err_cnt, 0);

    // single inverted bit while locked
    $display("[TB] single bit error while locked");
    gstep(1'b1, 1'b1, 1'b0);
    chk("single_err", if16.err, 1);
    chk("single_cnt", if16.err_cnt, 1);
    for (int i = 0; i < 30; i++) gstep(1'b1, 1'b0, 1'b0);
    chk("single_locked", if16.locked, 1);
    chk("single_cnt_hold", if16.err_cnt, 1);

    // four errors inside one frame drop lock; 16 clean bits relock
    $display("[TB] four errors in one frame");
    for (int k = 0; k < 63 && m_frame != 0; k++) gstep(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      gstep(1'b1, 1'b1, 1'b0);
      if (e < 3) begin
        chk("burst_still_locked", if16.locked, 1);
        for (int i = 0; i < 3; i++) gstep(1'b1, 1'b0, 1'b0);
      end
    end
    chk("burst_unlock", if16.locked, 0);
    chk("burst_cnt", if16.err_cnt, 5);
    for (int i = 1; i <= 16; i++) begin
      gstep(1'b1, 1'b0, 1'b0);
      if (i == 15) chk("relock_pre", if16.locked, 0);
    end
    chk("relock16", if16.locked, 1);
    chk("relock_cnt_kept", if16.err_cnt, 5);

    // stuck-at-0 line never locks
    $display("[TB] stuck-at-0 line");
    pulse_reset();
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
    chk("stuck_locked", if16.locked, 0);
    chk("stuck_cnt", if16.err_cnt, 0);

    // random enable gating on a clean locked stream, then reset mid-stream
    $display("[TB] gated enable while locked, then reset");
    pulse_reset();
    wait_lock("gate_lock");
    for (int i = 0; i < 300; i++) gstep(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    chk("gate_locked", if16.locked, 1);
    chk("gate_cnt", if16.err_cnt, 0);
    pulse_reset();

    // 20 errors while locked saturate the 4-bit counter; clr beats an error
    $display("[TB] saturation and clear");
    wait_lock("sat_lock");
    for (int e = 0; e < 20; e++) begin
      wait_lock("sat_relock");
      gstep(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) gstep(1'b1, 1'b0, 1'b0);
    end
    chk("sat4", if4.err_cnt, 15);
    chk("sat16", if16.err_cnt, 20);
    wait_lock("clr_lock");
    gstep(1'b1, 1'b1, 1'b1);
    chk("clr_err", if16.err, 1);
    chk("clr_cnt16", if16.err_cnt, 0);
    chk("clr_cnt4", if4.err_cnt, 0);

    // randomized mix of gaps, bit errors, clears and resets
    $display("[TB] randomized traffic, 1500 cycles");
    for (int i = 0; i < 1500; i++) begin
      bit e, f, c;
      e = ($urandom_range(99, 0) < 80);
      f = ($urandom_range(99, 0) < 3);
      c = e && ($urandom_range(99, 0) < 1);
      if ($urandom_range(999, 0) < 2) pulse_reset();
      else gstep(e, f, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
